// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_stream_reader_pkg;

    localparam int BEAT_CNT_W = 32;

    function automatic bit read_latency_ok(input int rl);
        return (rl == 1) || (rl == 2);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small register-based circular buffer with push/pop, occupancy and head output.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ,
    output logic             valid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid     = (occ != '0);
    assign pop_ok    = pop & valid;
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (clr) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop_ok) begin
                head <= ptr_inc(head);
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    // The upstream credit scheme must never let a push land on a full buffer.
    assert property (@(posedge clk) disable iff (clr)
        !(push && !pop_ok && (occ == OCC_W'(DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns a fixed-latency BRAM FIFO read port into a valid/ready stream,
// issuing reads only when the prefetch buffer has room for every word in flight.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_out,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [BEAT_CNT_W-1:0] beat_count
);

    localparam int BUF_DEPTH = READ_LATENCY + 1;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    logic [READ_LATENCY-1:0] rd_pipe;
    logic [OCC_W-1:0]        occ;
    logic [OCC_W-1:0]        inflight;
    logic [OCC_W:0]          credit_used;
    logic                    pop;
    logic                    push;

    assign pop = out_valid & out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OCC_W'(rd_pipe[i]);
        end
    end

    // A word leaving the buffer this cycle already frees its slot for a new read.
    assign credit_used = (OCC_W + 1)'(occ) + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);
    assign fifo_rd_en  = !rst && !flush && !fifo_empty
                         && (credit_used < (OCC_W + 1)'(BUF_DEPTH));

    // Clearing the pipe bits is what makes late BRAM returns after a flush harmless.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= fifo_rd_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign push = rd_pipe[READ_LATENCY-1] & ~flush;

    stream_skid_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk       (clk),
        .clr       (rst | flush),
        .push      (push),
        .push_data (fifo_out),
        .pop       (pop),
        .head_data (out_data),
        .occ       (occ),
        .valid     (out_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
        end else if (pop && !flush) begin
            beat_count <= beat_count + BEAT_CNT_W'(1);
        end
    end

    assert property (@(posedge clk) read_latency_ok(READ_LATENCY));

endmodule
